// File: rtl/nco_sweep_ctrl.sv
// Frequency-sweep controller: loads start_word, then adds step_word every dwell period for num_steps steps.
// Optional build macro SWEEP_LOOP_EN: restart from start_word indefinitely instead of signalling done.
module nco_sweep_ctrl #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic [WIDTH-1:0] start_word,
  input  logic [WIDTH-1:0] step_word,
  input  logic [CNT_W-1:0] num_steps,
  input  logic [CNT_W-1:0] dwell,
  output logic [WIDTH-1:0] freq_word_out,
  output logic             freq_we_out,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DWELL = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_start_word;
  logic [WIDTH-1:0] r_step_word;
  logic [CNT_W-1:0] r_num_steps;
  logic [CNT_W-1:0] r_dwell_m1;
  logic [CNT_W-1:0] r_step_cnt;
  logic [CNT_W-1:0] r_dwell_cnt;
  logic [WIDTH-1:0] r_freq_word;
  logic             r_freq_we;
  logic             r_busy;
  logic             r_done;

  logic [CNT_W-1:0] w_dwell_m1;
  logic             w_last_step;
  logic [WIDTH-1:0] w_next_word;

  // A dwell of zero behaves as a dwell of one cycle.
  assign w_dwell_m1  = (dwell == '0) ? '0 : CNT_W'(dwell - CNT_W'(1));
  assign w_last_step = (r_step_cnt == r_num_steps);
  assign w_next_word = WIDTH'(r_freq_word + r_step_word);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_start_word <= '0;
      r_step_word  <= '0;
      r_num_steps  <= '0;
      r_dwell_m1   <= '0;
      r_step_cnt   <= '0;
      r_dwell_cnt  <= '0;
      r_freq_word  <= '0;
      r_freq_we    <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_freq_we <= 1'b0;
      r_done    <= 1'b0;
      if (stop) begin
        // Abort: word output holds its last value, no done pulse.
        r_state <= S_IDLE;
        r_busy  <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (start) begin
              r_start_word <= start_word;
              r_step_word  <= step_word;
              r_num_steps  <= num_steps;
              r_dwell_m1   <= w_dwell_m1;
              r_freq_word  <= start_word;
              r_freq_we    <= 1'b1;
              r_busy       <= 1'b1;
              r_step_cnt   <= '0;
              r_dwell_cnt  <= w_dwell_m1;
              r_state      <= S_DWELL;
            end
          end
          S_DWELL: begin
            if (r_dwell_cnt != '0) begin
              r_dwell_cnt <= CNT_W'(r_dwell_cnt - CNT_W'(1));
            end else if (!w_last_step) begin
              r_freq_word <= w_next_word;
              r_freq_we   <= 1'b1;
              r_step_cnt  <= CNT_W'(r_step_cnt + CNT_W'(1));
              r_dwell_cnt <= r_dwell_m1;
            end else begin
`ifdef SWEEP_LOOP_EN
              r_freq_word <= r_start_word;
              r_freq_we   <= 1'b1;
              r_step_cnt  <= '0;
              r_dwell_cnt <= r_dwell_m1;
`else
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= S_DONE;
`endif
            end
          end
          S_DONE: begin
            r_state <= S_IDLE;
          end
          default: begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign freq_word_out = r_freq_word;
  assign freq_we_out   = r_freq_we;
  assign busy          = r_busy;
  assign done          = r_done;

endmodule

// File: tb/tb_nco_sweep_ctrl.sv
// Directed self-checking bench for nco_sweep_ctrl (default build, single sweep).
`timescale 1ns/1ps
module tb_nco_sweep_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        stop;
  logic [31:0] start_word;
  logic [31:0] step_word;
  logic [15:0] num_steps;
  logic [15:0] dwell;
  logic [31:0] freq_word_out;
  logic        freq_we_out;
  logic        busy;
  logic        done;

  int checks   = 0;
  int failures = 0;

  nco_sweep_ctrl #(.WIDTH(32), .CNT_W(16)) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .stop          (stop),
    .start_word    (start_word),
    .step_word     (step_word),
    .num_steps     (num_steps),
    .dwell         (dwell),
    .freq_word_out (freq_word_out),
    .freq_we_out   (freq_we_out),
    .busy          (busy),
    .done          (done)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [31:0] e_word, input logic e_we,
                         input logic e_busy, input logic e_done);
    chk({tag, ".word"}, freq_word_out, e_word);
    chk({tag, ".we"},   32'(freq_we_out), 32'(e_we));
    chk({tag, ".busy"}, 32'(busy),        32'(e_busy));
    chk({tag, ".done"}, 32'(done),        32'(e_done));
  endtask

  initial begin
    logic [31:0] e_word;
    logic        e_we;
    logic        e_busy;
    logic        e_done;

    // Reset held with start asserted: nothing may happen.
    rst = 1'b1; start = 1'b1; stop = 1'b0;
    start_word = 32'd100; step_word = 32'd5; num_steps = 16'd3; dwell = 16'd4;
    tick(); tick();
    chk_all("reset", 32'd0, 1'b0, 1'b0, 1'b0);
    start = 1'b0;
    rst = 1'b0;
    tick(); tick();
    chk_all("post_reset_idle", 32'd0, 1'b0, 1'b0, 1'b0);

    // Basic sweep with config churn and a mid-sweep start pulse.
    start = 1'b1;
    tick();
    for (int c = 1; c <= 18; c++) begin
      e_we   = (c <= 13) && (((c - 1) % 4) == 0);
      e_busy = (c <= 16);
      e_done = (c == 17);
      e_word = (c <= 13) ? 32'(100 + 5 * ((c - 1) / 4)) : 32'd115;
      chk_all($sformatf("basic.c%0d", c), e_word, e_we, e_busy, e_done);
      start = (c == 3);
      if (c == 1) begin
        start_word = 32'd999; step_word = 32'd77; num_steps = 16'd9; dwell = 16'd2;
      end
      if (c < 18) tick();
    end

    // dwell=0, num_steps=0: one word, done next cycle.
    start_word = 32'd7; step_word = 32'd1; num_steps = 16'd0; dwell = 16'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk_all("d0.c1", 32'd7, 1'b1, 1'b1, 1'b0);
    tick();
    chk_all("d0.c2", 32'd7, 1'b0, 1'b0, 1'b1);
    tick();
    chk_all("d0.c3", 32'd7, 1'b0, 1'b0, 1'b0);

    // Modulo wrap of the tuning word.
    start_word = 32'hFFFF_FFFE; step_word = 32'd3; num_steps = 16'd1; dwell = 16'd1;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk_all("wrap.c1", 32'hFFFF_FFFE, 1'b1, 1'b1, 1'b0);
    tick();
    chk_all("wrap.c2", 32'h0000_0001, 1'b1, 1'b1, 1'b0);
    tick();
    chk_all("wrap.c3", 32'h0000_0001, 1'b0, 1'b0, 1'b1);
    tick();

    // Start together with stop in IDLE: stop wins.
    start_word = 32'd100; step_word = 32'd5; num_steps = 16'd3; dwell = 16'd4;
    start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    chk_all("start_stop_idle", 32'h0000_0001, 1'b0, 1'b0, 1'b0);

    // Abort sampled at the end of cycle 6.
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      if (c <= 6) begin
        e_we   = (((c - 1) % 4) == 0);
        e_busy = 1'b1;
        e_word = 32'(100 + 5 * ((c - 1) / 4));
      end else begin
        e_we   = 1'b0;
        e_busy = 1'b0;
        e_word = 32'd105;
      end
      chk_all($sformatf("abort.c%0d", c), e_word, e_we, e_busy, 1'b0);
      stop = (c == 6);
      if (c < 20) tick();
    end
    stop = 1'b0;

    // Asynchronous reset mid-sweep clears outputs without a clock edge.
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick(); tick();
    chk_all("pre_async_rst.c5", 32'd105, 1'b1, 1'b1, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk_all("async_rst", 32'd0, 1'b0, 1'b0, 1'b0);
    tick();
    rst = 1'b0;
    for (int c = 0; c < 25; c++) tick();
    chk_all("after_async_rst", 32'd0, 1'b0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
